// File: rtl/permute_result_forwarder.sv
// rtl/permute_result_forwarder.sv - Permute result pipeline with commit and 3-source forwarding.
// Optional zero-cycle input bypass on forwarding: define PERMUTE_FWD_BYPASS_EN.
module permute_result_forwarder #(
    parameter int DEPTH        = 4,
    parameter int DATA_W       = 128,
    parameter int ADDR_W       = 7,
    parameter int FLUSH_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_reg_addr,
    input  logic              in_enable_reg_write,
    input  logic              branch_is_taken,
    input  logic              stall,
    input  logic [ADDR_W-1:0] fwd_addr_a,
    input  logic [ADDR_W-1:0] fwd_addr_b,
    input  logic [ADDR_W-1:0] fwd_addr_c,
    output logic              fwd_hit_a,
    output logic              fwd_hit_b,
    output logic              fwd_hit_c,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic [DATA_W-1:0] fwd_data_b,
    output logic [DATA_W-1:0] fwd_data_c,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [3:0]        occupancy
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [3:0]        occupancy_q, occupancy_d;

    logic [ADDR_W-1:0] src_addr [3];
    logic              src_hit  [3];
    logic [DATA_W-1:0] src_data [3];
    logic              commit_en;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (!stall) begin
            valid_d[0] = in_enable_reg_write;
            addr_d[0]  = in_reg_addr;
            data_d[0]  = in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                addr_d[i]  = addr_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
        // Flush applies to post-edge positions, whether shifted in or held in place.
        if (branch_is_taken) begin
            for (int i = 0; i < FLUSH_STAGES; i++) begin
                valid_d[i] = 1'b0;
            end
        end
        occupancy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_d = occupancy_d + 4'(valid_d[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            occupancy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            occupancy_q <= occupancy_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign commit_en     = valid_q[DEPTH-1] && !stall;
    assign rf_write_en   = commit_en;
    assign rf_write_addr = commit_en ? addr_q[DEPTH-1] : '0;
    assign rf_write_data = commit_en ? data_q[DEPTH-1] : '0;
    assign occupancy     = occupancy_q;

    assign src_addr[0] = fwd_addr_a;
    assign src_addr[1] = fwd_addr_b;
    assign src_addr[2] = fwd_addr_c;

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            src_hit[s]  = 1'b0;
            src_data[s] = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (valid_q[i] && addr_q[i] == src_addr[s]) begin
                    src_hit[s]  = 1'b1;
                    src_data[s] = data_q[i];
                end
            end
`ifdef PERMUTE_FWD_BYPASS_EN
            if (reset && in_enable_reg_write && !branch_is_taken && in_reg_addr == src_addr[s]) begin
                src_hit[s]  = 1'b1;
                src_data[s] = in_data;
            end
`endif
        end
    end

    assign fwd_hit_a  = src_hit[0];
    assign fwd_hit_b  = src_hit[1];
    assign fwd_hit_c  = src_hit[2];
    assign fwd_data_a = src_data[0];
    assign fwd_data_b = src_data[1];
    assign fwd_data_c = src_data[2];

endmodule
